// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM gate-drive generator with dead-time insertion.
// Period counter compared against a double-buffered duty value; a dead-time
// FSM turns the compare result into non-overlapping high/low-side drives.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   OFF   | not running, both switches off
//   DT_HS | dead time before the high-side switch turns on
//   HS_ON | high-side switch on
//   DT_LS | dead time before the low-side switch turns on
//   LS_ON | low-side switch on
module pwm_deadtime_gen #(
  parameter int N = 8,
  parameter int D = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_enable,
  input  logic [N-1:0] i_period,
  input  logic [N-1:0] i_duty,
  input  logic [D-1:0] i_deadtime,
  input  logic         i_load,
  output logic         o_hs,
  output logic         o_ls,
  output logic         o_cycle_start,
  output logic [N-1:0] o_count
);

  localparam logic [N-1:0] ONE    = N'(1);
  localparam logic [N-1:0] TWO    = N'(2);
  localparam logic [D-1:0] DT_ONE = D'(1);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    DT_HS = 3'd1,
    HS_ON = 3'd2,
    DT_LS = 3'd3,
    LS_ON = 3'd4
  } state_t;

  state_t       state;
  logic [N-1:0] per_s;
  logic [N-1:0] duty_s;
  logic [D-1:0] dt_s;
  logic [D-1:0] dt_cnt;
  logic [N-1:0] count;
  logic         load_pending;
  logic         raw;
  logic         run;
  logic         wrap;
  logic         shadow_upd;

  // A period shorter than 2 cycles cannot hold any dead time, so treat it as stopped.
  assign run        = i_enable && (per_s >= TWO);
  assign wrap       = run && (count == per_s - ONE);
  // Shadows only move at a period boundary, or freely while the stage is stopped.
  assign shadow_upd = load_pending && (wrap || !run);

  assign o_cycle_start = (count == '0) && run;
  assign o_count       = count;

  // Shadow registers and the pending-load flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_s        <= i_period;
      duty_s       <= i_duty;
      dt_s         <= i_deadtime;
      load_pending <= 1'b0;
    end else if (shadow_upd) begin
      per_s        <= i_period;
      duty_s       <= i_duty;
      dt_s         <= i_deadtime;
      // A strobe landing on the update cycle re-arms so the newest inputs still win.
      load_pending <= i_load;
    end else if (i_load) begin
      load_pending <= 1'b1;
    end
  end

  // Period counter: 0 .. per_s-1, held at 0 while stopped.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  // Registered duty compare feeding the dead-time FSM.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      raw <= 1'b0;
    end else begin
      raw <= (count < duty_s);
    end
  end

  // Dead-time FSM with registered gate outputs.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      state  <= OFF;
      dt_cnt <= '0;
      o_hs   <= 1'b0;
      o_ls   <= 1'b0;
    end else begin
      o_hs <= 1'b0;
      o_ls <= 1'b0;
      case (state)
        OFF: begin
          state  <= raw ? DT_HS : DT_LS;
          dt_cnt <= dt_s;
        end
        DT_HS: begin
          if (!raw) begin
            state  <= DT_LS;
            dt_cnt <= dt_s;
          end else if (dt_cnt == '0) begin
            state <= HS_ON;
            o_hs  <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - DT_ONE;
          end
        end
        HS_ON: begin
          if (!raw) begin
            state  <= DT_LS;
            dt_cnt <= dt_s;
          end else begin
            o_hs <= 1'b1;
          end
        end
        DT_LS: begin
          if (raw) begin
            state  <= DT_HS;
            dt_cnt <= dt_s;
          end else if (dt_cnt == '0) begin
            state <= LS_ON;
            o_ls  <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - DT_ONE;
          end
        end
        LS_ON: begin
          if (raw) begin
            state  <= DT_HS;
            dt_cnt <= dt_s;
          end else begin
            o_ls <= 1'b1;
          end
        end
        default: begin
          state  <= OFF;
          dt_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: hand-computed edge timing and per-window
// on-time totals, plus a cycle-by-cycle shoot-through monitor.
module tb_pwm_deadtime_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] per;
  logic [7:0] duty;
  logic [5:0] dt;
  logic       load;
  logic       hs;
  logic       ls;
  logic       cs;
  logic [7:0] count;

  int passed  = 0;
  int total   = 0;
  int fails   = 0;
  int overlap = 0;
  int w_hs, w_ls, w_cs, w_off, w_cmax;

  pwm_deadtime_gen #(.N(8), .D(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (en),
    .i_period      (per),
    .i_duty        (duty),
    .i_deadtime    (dt),
    .i_load        (load),
    .o_hs          (hs),
    .o_ls          (ls),
    .o_cycle_start (cs),
    .o_count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shoot-through monitor over the whole run.
  always @(negedge clk) begin
    if (hs && ls) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic window(input int n);
    w_hs = 0; w_ls = 0; w_cs = 0; w_off = 0; w_cmax = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (hs) w_hs++;
      if (ls) w_ls++;
      if (cs) w_cs++;
      if (!hs && !ls) w_off++;
      if (int'(count) > w_cmax) w_cmax = int'(count);
    end
  endtask

  // Load new shadow values while stopped: strobe sets pending, next edge loads.
  task automatic load_stopped(input int p, input int d, input int t);
    en   = 1'b0;
    per  = 8'(p);
    duty = 8'(d);
    dt   = 6'(t);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; per = 8'd10; duty = 8'd4; dt = 6'd2; load = 1'b0;
    ticks(2);
    chk("reset_count", count, 0);
    chk("reset_hs", hs, 0);
    chk("reset_ls", ls, 0);
    chk("reset_cs", cs, 0);
    reset = 1'b0;
    tick();
    chk("idle_cs", cs, 0);

    // per=10 duty=4 dt=2
    en = 1'b1;
    #1;
    chk("start_cs", cs, 1);
    ticks(5);
    chk("t1_hs_on_e5", hs, 1);
    chk("t1_count_e5", count, 5);
    chk("t1_ls_e5", ls, 0);
    tick();
    chk("t1_hs_off_e6", hs, 0);
    ticks(3);
    chk("t1_ls_on_e9", ls, 1);
    window(10);
    chk("t1_hs_cycles", w_hs, 1);
    chk("t1_ls_cycles", w_ls, 3);
    chk("t1_cs_pulses", w_cs, 1);
    chk("t1_off_cycles", w_off, 6);
    chk("t1_count_max", w_cmax, 9);

    // mid-period duty change to 7 takes effect only at the next period
    duty = 8'd7;
    load = 1'b1;
    tick();
    load = 1'b0;
    window(9);
    chk("t3_old_period_hs", w_hs, 1);
    window(10);
    chk("t3_new_period_hs", w_hs, 4);
    window(10);
    chk("t3_steady_hs", w_hs, 4);
    chk("t3_steady_ls", w_ls, 0);
    chk("t3_steady_cs", w_cs, 1);

    // duty=0: low side only, after a 3-cycle gap
    load_stopped(10, 0, 2);
    chk("t2_disabled_hs", hs, 0);
    chk("t2_disabled_count", count, 0);
    en = 1'b1;
    ticks(3);
    chk("t2_d0_gap_ls", ls, 0);
    tick();
    chk("t2_d0_ls_on", ls, 1);
    window(20);
    chk("t2_d0_hs", w_hs, 0);
    chk("t2_d0_ls", w_ls, 20);

    // duty=10 (>= per): high side only
    load_stopped(10, 10, 2);
    en = 1'b1;
    ticks(4);
    chk("t2_d10_gap_hs", hs, 0);
    tick();
    chk("t2_d10_hs_on", hs, 1);
    window(20);
    chk("t2_d10_hs", w_hs, 20);
    chk("t2_d10_ls", w_ls, 0);

    // duty=3 dt=3: high-side on-time non-positive
    load_stopped(10, 3, 3);
    en = 1'b1;
    window(30);
    window(20);
    chk("t4_hs_never", w_hs, 0);
    chk("t4_ls_cycles", w_ls, 6);

    // randomised sweep, checked by the overlap monitor
    for (int k = 0; k < 8; k++) begin
      per  = 8'($urandom_range(0, 20));
      duty = 8'($urandom_range(0, 22));
      dt   = 6'($urandom_range(0, 6));
      load = 1'b1;
      tick();
      load = 1'b0;
      window(45);
    end

    // enable dropped in HS_ON
    load_stopped(10, 7, 2);
    en = 1'b1;
    ticks(5);
    chk("t5_hs_on", hs, 1);
    en = 1'b0;
    tick();
    chk("t5_drop_hs", hs, 0);
    chk("t5_drop_ls", ls, 0);
    chk("t5_drop_count", count, 0);
    chk("t5_drop_cs", cs, 0);
    load_stopped(10, 0, 2);
    en = 1'b1;
    ticks(3);
    chk("t5_reen_gap_ls", ls, 0);
    tick();
    chk("t5_reen_ls_on", ls, 1);
    ticks(3);
    reset = 1'b1;
    tick();
    chk("t5_rst_hs", hs, 0);
    chk("t5_rst_ls", ls, 0);
    chk("t5_rst_count", count, 0);

    // per=1 then per=0: held idle
    per = 8'd1; duty = 8'd4; dt = 6'd2; en = 1'b0;
    tick();
    reset = 1'b0;
    en = 1'b1;
    #1;
    chk("t6_p1_cs_now", cs, 0);
    window(15);
    chk("t6_p1_hs", w_hs, 0);
    chk("t6_p1_ls", w_ls, 0);
    chk("t6_p1_cs", w_cs, 0);
    chk("t6_p1_count", w_cmax, 0);
    per  = 8'd0;
    load = 1'b1;
    tick();
    load = 1'b0;
    window(15);
    chk("t6_p0_hs", w_hs, 0);
    chk("t6_p0_ls", w_ls, 0);
    chk("t6_p0_cs", w_cs, 0);
    chk("t6_p0_count", w_cmax, 0);

    chk("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
